wb_rr_mem_arbiter: RTL and testbench

//  Round-robin Wishbone B3 arbiter sharing one slave (main RAM port) between N masters:
//   or1200 IWB, or1200 DWB and the adbg debug master.

---
 rtl/wb_rr_mem_arbiter_if.sv | 47 ++++
 rtl/wb_rr_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_rr_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rr_mem_arbiter_if.sv
// Wishbone bus bundle between N masters, the round-robin arbiter and the shared RAM slave.
// The slave modport is the arbiter's view; master is the surrounding masters + RAM.
interface wb_rr_mem_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  logic [NUM_MASTERS*AW-1:0]     wbm_adr_i;
  logic [NUM_MASTERS*DW-1:0]     wbm_dat_i;
  logic [NUM_MASTERS*DW/8-1:0]   wbm_sel_i;
  logic [NUM_MASTERS-1:0]        wbm_we_i;
  logic [NUM_MASTERS-1:0]        wbm_cyc_i;
  logic [NUM_MASTERS-1:0]        wbm_stb_i;
  logic [NUM_MASTERS*3-1:0]      wbm_cti_i;
  logic [NUM_MASTERS*2-1:0]      wbm_bte_i;
  logic [DW-1:0]                 wbm_dat_o;
  logic [NUM_MASTERS-1:0]        wbm_ack_o;
  logic [NUM_MASTERS-1:0]        wbm_err_o;
  logic [NUM_MASTERS-1:0]        wbm_rty_o;

  logic [AW-1:0]                 wbs_adr_o;
  logic [DW-1:0]                 wbs_dat_o;
  logic [DW/8-1:0]               wbs_sel_o;
  logic                          wbs_we_o;
  logic                          wbs_cyc_o;
  logic                          wbs_stb_o;
  logic [2:0]                    wbs_cti_o;
  logic [1:0]                    wbs_bte_o;
  logic [DW-1:0]                 wbs_dat_i;
  logic                          wbs_ack_i;
  logic                          wbs_err_i;
  logic                          wbs_rty_i;

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );
endinterface

// File: rtl/wb_rr_mem_arbiter.sv
// Round-robin Wishbone B3 arbiter: N masters share one RAM slave, grant held for the whole cyc.
// Optional stalled-access timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_mem_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 256
)(
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_rr_mem_arbiter_if.slave     bus,
  output logic [NUM_MASTERS-1:0] grant_o
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int SW = DW/8;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("wb_rr_mem_arbiter: unsupported NUM_MASTERS or TIMEOUT_CYCLES");
  end

  typedef enum logic {S_IDLE, S_GRANTED} state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  // r_last doubles as the owner index while GRANTED
  logic [IW-1:0]          r_last, w_last_nxt;
  logic [IW-1:0]          w_win;
  logic                   w_any;
  logic                   w_active;
  logic                   w_timeout;

  assign w_any = |bus.wbm_cyc_i;

  // Search last+1, last+2, ... and take the first master holding cyc
  always_comb begin
    int j;
    logic found;
    j     = 0;
    found = 1'b0;
    w_win = r_last;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      j = (int'(r_last) + i) % NUM_MASTERS;
      if (!found && bus.wbm_cyc_i[j]) begin
        found = 1'b1;
        w_win = IW'(j);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= IW'(NUM_MASTERS-1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_GRANTED;
          w_grant_nxt = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_win;
          w_last_nxt  = w_win;
        end
      end
      S_GRANTED: begin
        if (!bus.wbm_cyc_i[r_last]) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Outputs are also suppressed in a reset cycle so no ack leaks to an aborted owner
  assign w_active = (r_state == S_GRANTED) && !wb_rst_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);
  logic [CW-1:0] r_to_cnt;
  logic          w_resp;

  assign w_resp    = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
  assign w_timeout = w_active && (r_to_cnt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || r_state != S_GRANTED || w_resp || w_timeout)
      r_to_cnt <= '0;
    else if (bus.wbm_cyc_i[r_last] && bus.wbm_stb_i[r_last])
      r_to_cnt <= r_to_cnt + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    bus.wbs_adr_o = '0;
    bus.wbs_dat_o = '0;
    bus.wbs_sel_o = '0;
    bus.wbs_we_o  = 1'b0;
    bus.wbs_cyc_o = 1'b0;
    bus.wbs_stb_o = 1'b0;
    bus.wbs_cti_o = '0;
    bus.wbs_bte_o = '0;
    bus.wbm_ack_o = '0;
    bus.wbm_err_o = '0;
    bus.wbm_rty_o = '0;
    if (w_active) begin
      bus.wbs_adr_o = bus.wbm_adr_i[r_last*AW +: AW];
      bus.wbs_dat_o = bus.wbm_dat_i[r_last*DW +: DW];
      bus.wbs_sel_o = bus.wbm_sel_i[r_last*SW +: SW];
      bus.wbs_we_o  = bus.wbm_we_i[r_last];
      bus.wbs_cyc_o = bus.wbm_cyc_i[r_last] & ~w_timeout;
      bus.wbs_stb_o = bus.wbm_stb_i[r_last] & ~w_timeout;
      bus.wbs_cti_o = bus.wbm_cti_i[r_last*3 +: 3];
      bus.wbs_bte_o = bus.wbm_bte_i[r_last*2 +: 2];
      bus.wbm_ack_o[r_last] = bus.wbs_ack_i & ~w_timeout;
      bus.wbm_err_o[r_last] = (bus.wbs_err_i & ~w_timeout) | w_timeout;
      bus.wbm_rty_o[r_last] = bus.wbs_rty_i & ~w_timeout;
    end
  end

  assign bus.wbm_dat_o = bus.wbs_dat_i;
  assign grant_o       = r_grant;
endmodule

// File: tb/tb_wb_rr_mem_arbiter.sv
// Directed bench for wb_rr_mem_arbiter (3 masters, TIMEOUT_CYCLES=16); the bench plays masters and RAM.
module tb_wb_rr_mem_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam logic [31:0] SLV_DAT = 32'hCAFE_5A5A;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] grant;
  logic         slv_auto = 1'b0;
  logic         slv_ack  = 1'b0;
  int           n_tests  = 0;
  int           n_fail   = 0;

  wb_rr_mem_arbiter_if #(.NUM_MASTERS(N), .AW(AW), .DW(DW)) bus ();

  wb_rr_mem_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus),
    .grant_o  (grant)
  );

  always #5 clk = ~clk;

  assign bus.wbs_ack_i = slv_auto ? (bus.wbs_cyc_o & bus.wbs_stb_o) : slv_ack;
  assign bus.wbs_err_i = 1'b0;
  assign bus.wbs_rty_i = 1'b0;
  assign bus.wbs_dat_i = SLV_DAT;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    slv_auto = 1'b0;
    slv_ack  = 1'b0;
    bus.wbm_cyc_i = '0;
    bus.wbm_stb_i = '0;
    bus.wbm_cti_i = '0;
    bus.wbm_bte_i = '0;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] a;
    logic [N-1:0] prev;
    logic [N-1:0] seen [16];
    logic [N-1:0] exp2 [7];
    logic [N-1:0] exp3 [3];
    int           nchg;
    int           acks1, acks2;
    int           nerr, first_err;
    logic         stb_at_err;

    bus.wbm_adr_i = '0;
    bus.wbm_dat_i = '0;
    bus.wbm_sel_i = '0;
    bus.wbm_we_i  = '0;
    do_reset();

    // Reset state
    smp();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_wbs_cyc", 32'(bus.wbs_cyc_o), 0);
    chk("rst_ack", 32'(bus.wbm_ack_o), 0);

    // 1: master 1 alone, slave acks in cycle 2
    nxt();
    bus.wbm_adr_i[1*AW +: AW] = 32'h1000_0040;
    bus.wbm_sel_i[4 +: 4]     = 4'hF;
    bus.wbm_cyc_i = 3'b010;
    bus.wbm_stb_i = 3'b010;
    smp();
    chk("t1_c0_wbs_cyc", 32'(bus.wbs_cyc_o), 0);
    nxt();
    smp();
    chk("t1_c1_wbs_cyc", 32'(bus.wbs_cyc_o), 1);
    chk("t1_c1_adr", bus.wbs_adr_o, 32'h1000_0040);
    chk("t1_c1_grant", 32'(grant), 32'b010);
    chk("t1_c1_ack", 32'(bus.wbm_ack_o), 0);
    nxt();
    slv_ack = 1'b1;
    smp();
    chk("t1_c2_ack", 32'(bus.wbm_ack_o), 32'b010);
    chk("t1_c2_dat", bus.wbm_dat_o, SLV_DAT);
    nxt();
    slv_ack = 1'b0;
    bus.wbm_cyc_i = '0;
    bus.wbm_stb_i = '0;
    smp();
    chk("t1_c3_grant", 32'(grant), 32'b010);
    nxt();
    smp();
    chk("t1_c4_grant", 32'(grant), 0);
    chk("t1_c4_wbs_cyc", 32'(bus.wbs_cyc_o), 0);

    // 2: all masters request continuously, single beats
    exp2 = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    do_reset();
    slv_auto = 1'b1;
    bus.wbm_cyc_i = 3'b111;
    bus.wbm_stb_i = 3'b111;
    prev = '0;
    nchg = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        nxt();
        for (int k = 0; k < N; k++) begin
          bus.wbm_cyc_i[k] = !a[k];
          bus.wbm_stb_i[k] = !a[k];
        end
      end
      smp();
      a = bus.wbm_ack_o;
      if (grant != prev && nchg < 16) begin
        seen[nchg] = grant;
        nchg++;
      end
      prev = grant;
    end
    chk("t2_nchg_ge7", 32'(nchg >= 7), 1);
    for (int i = 0; i < 7; i++)
      chk($sformatf("t2_seq%0d", i), 32'(seen[i]), 32'(exp2[i]));

    // 3: master 1 4-beat incrementing burst while master 2 waits
    exp3 = '{3'b010, 3'b000, 3'b100};
    do_reset();
    slv_auto = 1'b1;
    acks1 = 0;
    acks2 = 0;
    prev  = '0;
    nchg  = 0;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) nxt();
      bus.wbm_cyc_i[1] = (acks1 < 4);
      bus.wbm_stb_i[1] = (acks1 < 4);
      bus.wbm_cti_i[3 +: 3] = (acks1 == 3) ? 3'b111 : 3'b010;
      bus.wbm_cyc_i[2] = 1'b1;
      bus.wbm_stb_i[2] = 1'b1;
      smp();
      if (c == 1) chk("t3_cti_first", 32'(bus.wbs_cti_o), 32'b010);
      if (c == 4) chk("t3_cti_last", 32'(bus.wbs_cti_o), 32'b111);
      if (bus.wbm_ack_o[1]) acks1++;
      if (bus.wbm_ack_o[2] && c < 7) acks2++;
      if (grant != prev && nchg < 16) begin
        seen[nchg] = grant;
        nchg++;
      end
      prev = grant;
    end
    chk("t3_acks_m1", acks1, 4);
    chk("t3_acks_m2_during", acks2, 0);
    chk("t3_nchg", nchg, 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t3_seq%0d", i), 32'(seen[i]), 32'(exp3[i]));

    // 4: reset in master 0's second burst beat
    do_reset();
    slv_auto = 1'b1;
    bus.wbm_cyc_i = 3'b001;
    bus.wbm_stb_i = 3'b001;
    bus.wbm_cti_i[0 +: 3] = 3'b010;
    nxt();
    smp();
    chk("t4_beat1_ack", 32'(bus.wbm_ack_o), 32'b001);
    nxt();
    rst = 1'b1;
    smp();
    chk("t4_rst_ack", 32'(bus.wbm_ack_o), 0);
    nxt();
    rst = 1'b0;
    bus.wbm_cyc_i = 3'b011;
    bus.wbm_stb_i = 3'b011;
    smp();
    chk("t4_after_grant", 32'(grant), 0);
    chk("t4_after_wbs_cyc", 32'(bus.wbs_cyc_o), 0);
    chk("t4_after_ack", 32'(bus.wbm_ack_o), 0);
    nxt();
    smp();
    chk("t4_regrant", 32'(grant), 32'b001);

    // 5: slave never responds
    do_reset();
    bus.wbm_cyc_i = 3'b001;
    bus.wbm_stb_i = 3'b001;
    nerr = 0;
    first_err = -1;
    stb_at_err = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 1; c <= 30; c++) begin
      nxt();
      smp();
      if (bus.wbm_err_o != 0) begin
        nerr++;
        if (first_err < 0) begin
          first_err  = c;
          stb_at_err = bus.wbs_stb_o;
        end
      end
    end
    chk("t5_first_err_cycle", first_err, TO + 1);
    chk("t5_err_count", nerr, 1);
    chk("t5_stb_at_err", 32'(stb_at_err), 0);
`else
    for (int c = 1; c <= 1000; c++) begin
      nxt();
      smp();
      if (bus.wbm_err_o != 0) nerr++;
    end
    chk("t5_no_err", nerr, 0);
    chk("t5_still_stalled", 32'(bus.wbs_stb_o), 1);
`endif
    chk("t5_grant_held", 32'(grant), 32'b001);

    // 6: master 0 drops cyc as master 2 raises it
    do_reset();
    slv_auto = 1'b1;
    bus.wbm_cyc_i = 3'b001;
    bus.wbm_stb_i = 3'b001;
    nxt();
    smp();
    chk("t6_c1_grant", 32'(grant), 32'b001);
    nxt();
    bus.wbm_cyc_i = 3'b100;
    bus.wbm_stb_i = 3'b100;
    smp();
    chk("t6_c2_grant", 32'(grant), 32'b001);
    nxt();
    smp();
    chk("t6_c3_idle", 32'(grant), 0);
    nxt();
    smp();
    chk("t6_c4_grant", 32'(grant), 32'b100);
    chk("t6_c4_ack", 32'(bus.wbm_ack_o), 32'b100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
